// File: rtl/fb_sprite_writer_pkg.sv
// Shared constants and FSM encoding for the sprite framebuffer writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_sprite_writer_pkg;

    localparam int DEF_HOR_BITS = 7;
    localparam int DEF_VER_BITS = 8;
    localparam int RGB_W        = 6;

    localparam logic [RGB_W-1:0] DEF_BALL_RGB = 6'b111111;
    localparam logic [RGB_W-1:0] DEF_BG_RGB   = 6'b000000;

    // ST_CLEAR is only reachable when the power-up clear is built in.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ERASE,
        ST_DRAW,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fb_sprite_writer_if.sv
// Request/SRAM-write bundle between the frame logic and the sprite writer.
// Latency: n/a (wires only).
// Backpressure: wr_win gates every write; frame_start/pos come from VGA timing and game logic.
// master: the writer (drives SRAM address/data/strobe and status).
// slave : the environment (drives frame_start, wr_win, ball position).
interface fb_sprite_writer_if
    import fb_sprite_writer_pkg::*;
#(
    parameter int HOR_BITS = DEF_HOR_BITS,
    parameter int VER_BITS = DEF_VER_BITS
);
    logic                frame_start;
    logic                wr_win;
    logic [HOR_BITS-1:0] hor_pos;
    logic [VER_BITS-1:0] ver_pos;
    logic [HOR_BITS-1:0] hor_addr;
    logic [VER_BITS-1:0] ver_addr;
    logic [RGB_W-1:0]    wdata;
    logic                we;
    logic                busy;
    logic                done;

    modport master (
        input  frame_start, wr_win, hor_pos, ver_pos,
        output hor_addr, ver_addr, wdata, we, busy, done
    );

    modport slave (
        output frame_start, wr_win, hor_pos, ver_pos,
        input  hor_addr, ver_addr, wdata, we, busy, done
    );
endinterface

// File: rtl/fb_sprite_writer_scanner.sv
// Walks a SPRITE_W x SPRITE_H box (dx fastest) from a base position; reports clipped address, skip and last.
// Latency: combinational address from registered dx/dy; counters step on the clock when adv is high.
// Backpressure: adv low holds the current pixel; counters wrap to 0 after the last pixel.
// Ports: clk/rst, adv (step), base_x/base_y (box origin), pix_x/pix_y (address), skip (off-screen), last.
module fb_sprite_writer_scanner #(
    parameter int HOR_BITS = 7,
    parameter int VER_BITS = 8,
    parameter int SPRITE_W = 4,
    parameter int SPRITE_H = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adv,
    input  logic [HOR_BITS-1:0] base_x,
    input  logic [VER_BITS-1:0] base_y,
    output logic [HOR_BITS-1:0] pix_x,
    output logic [VER_BITS-1:0] pix_y,
    output logic                skip,
    output logic                last
);
    localparam int DXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int DYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [DXW-1:0] DX_LAST = DXW'(SPRITE_W - 1);
    localparam logic [DYW-1:0] DY_LAST = DYW'(SPRITE_H - 1);

    logic [DXW-1:0]    dx;
    logic [DYW-1:0]    dy;
    logic [HOR_BITS:0] sum_x;
    logic [VER_BITS:0] sum_y;

    // One extra bit on each sum: a carry out means the pixel is past the screen edge.
    assign sum_x = {1'b0, base_x} + (HOR_BITS+1)'(dx);
    assign sum_y = {1'b0, base_y} + (VER_BITS+1)'(dy);
    assign pix_x = sum_x[HOR_BITS-1:0];
    assign pix_y = sum_y[VER_BITS-1:0];
    assign skip  = sum_x[HOR_BITS] | sum_y[VER_BITS];
    assign last  = (dx == DX_LAST) && (dy == DY_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx <= '0;
            dy <= '0;
        end else if (adv) begin
            if (dx == DX_LAST) begin
                dx <= '0;
                dy <= (dy == DY_LAST) ? '0 : dy + 1'b1;
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fb_sprite_writer.sv
// Framebuffer sprite writer: per frame erases the old ball box to BG_RGB, then draws it at the new position.
// Latency: addr/wdata/we registered, first write one cycle after wr_win is sampled high in ERASE/DRAW.
// Backpressure: wr_win low stalls on the current pixel; frame_start while busy lands in a 1-deep pending slot.
// Ports: clk, rst (async, active-high), bus (master modport: frame_start, wr_win, pos in; SRAM addr/wdata/we, busy, done out).
// Build option: FB_CLEAR_EN adds a post-reset CLEAR pass writing BG_RGB to the whole framebuffer.
module fb_sprite_writer
    import fb_sprite_writer_pkg::*;
#(
    parameter int               HOR_BITS = DEF_HOR_BITS,
    parameter int               VER_BITS = DEF_VER_BITS,
    parameter int               SPRITE_W = 4,
    parameter int               SPRITE_H = 4,
    parameter logic [RGB_W-1:0] BALL_RGB = DEF_BALL_RGB,
    parameter logic [RGB_W-1:0] BG_RGB   = DEF_BG_RGB
) (
    input  logic               clk,
    input  logic               rst,
    fb_sprite_writer_if.master bus
);
    state_t state, state_nxt;

    logic                drawn;
    logic [HOR_BITS-1:0] old_x, new_x, pend_x;
    logic [VER_BITS-1:0] old_y, new_y, pend_y;
    logic                pend_vld;

    logic                adv, wr_pix, pix_bg;
    logic                load_new, load_pend, pend_wr, pend_clr, commit;
    logic [HOR_BITS-1:0] pix_x, scan_x;
    logic [VER_BITS-1:0] pix_y, scan_y;
    logic                pix_skip, scan_skip, scan_last;

    logic [HOR_BITS-1:0] hor_q;
    logic [VER_BITS-1:0] ver_q;
    logic [RGB_W-1:0]    wdata_q;
    logic                we_q, busy_q, done_q;

`ifdef FB_CLEAR_EN
    logic [HOR_BITS+VER_BITS-1:0] clr_cnt;
    logic                         clr_last;
    assign clr_last = &clr_cnt;
`endif

    // Single scanner shared by both phases: ERASE walks the old box, everything else the new one.
    fb_sprite_writer_scanner #(
        .HOR_BITS(HOR_BITS), .VER_BITS(VER_BITS),
        .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .adv   (adv),
        .base_x((state == ST_ERASE) ? old_x : new_x),
        .base_y((state == ST_ERASE) ? old_y : new_y),
        .pix_x (scan_x),
        .pix_y (scan_y),
        .skip  (scan_skip),
        .last  (scan_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef FB_CLEAR_EN
            state <= ST_CLEAR;
`else
            state <= ST_IDLE;
`endif
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        adv       = 1'b0;
        wr_pix    = 1'b0;
        pix_bg    = 1'b1;
        load_new  = 1'b0;
        load_pend = 1'b0;
        pend_wr   = 1'b0;
        pend_clr  = 1'b0;
        commit    = 1'b0;
        pix_x     = scan_x;
        pix_y     = scan_y;
        pix_skip  = scan_skip;
        case (state)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    load_new  = 1'b1;
                    state_nxt = drawn ? ST_ERASE : ST_DRAW;
                end
            end
            ST_ERASE: begin
                pend_wr = bus.frame_start;
                if (bus.wr_win) begin
                    adv    = 1'b1;
                    wr_pix = 1'b1;
                    if (scan_last) state_nxt = ST_DRAW;
                end
            end
            ST_DRAW: begin
                pix_bg  = 1'b0;
                pend_wr = bus.frame_start;
                if (bus.wr_win) begin
                    adv    = 1'b1;
                    wr_pix = 1'b1;
                    if (scan_last) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // A request arriving now is newer than anything pending, so it wins.
                commit = 1'b1;
                if (bus.frame_start) begin
                    load_new  = 1'b1;
                    pend_clr  = 1'b1;
                    state_nxt = ST_ERASE;
                end else if (pend_vld) begin
                    load_pend = 1'b1;
                    pend_clr  = 1'b1;
                    state_nxt = ST_ERASE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
`ifdef FB_CLEAR_EN
            ST_CLEAR: begin
                pix_x    = clr_cnt[HOR_BITS-1:0];
                pix_y    = clr_cnt[HOR_BITS+VER_BITS-1:HOR_BITS];
                pix_skip = 1'b0;
                pend_wr  = bus.frame_start;
                if (bus.wr_win) begin
                    wr_pix = 1'b1;
                    if (clr_last) begin
                        // Screen is blank, so a queued request draws without erase.
                        pend_wr = 1'b0;
                        if (bus.frame_start) begin
                            load_new  = 1'b1;
                            pend_clr  = 1'b1;
                            state_nxt = ST_DRAW;
                        end else if (pend_vld) begin
                            load_pend = 1'b1;
                            pend_clr  = 1'b1;
                            state_nxt = ST_DRAW;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drawn    <= 1'b0;
            old_x    <= '0;
            old_y    <= '0;
            new_x    <= '0;
            new_y    <= '0;
            pend_x   <= '0;
            pend_y   <= '0;
            pend_vld <= 1'b0;
            hor_q    <= '0;
            ver_q    <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (load_new) begin
                new_x <= bus.hor_pos;
                new_y <= bus.ver_pos;
            end else if (load_pend) begin
                new_x <= pend_x;
                new_y <= pend_y;
            end
            if (pend_wr) begin
                pend_vld <= 1'b1;
                pend_x   <= bus.hor_pos;
                pend_y   <= bus.ver_pos;
            end else if (pend_clr) begin
                pend_vld <= 1'b0;
            end
            if (commit) begin
                old_x <= new_x;
                old_y <= new_y;
                drawn <= 1'b1;
            end
            // Clipped pixels keep the last address so the bus never shows a wrapped location.
            we_q <= wr_pix & ~pix_skip;
            if (wr_pix && !pix_skip) begin
                hor_q   <= pix_x;
                ver_q   <= pix_y;
                wdata_q <= pix_bg ? BG_RGB : BALL_RGB;
            end
            busy_q <= (state_nxt != ST_IDLE);
            done_q <= commit;
        end
    end

`ifdef FB_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR && bus.wr_win) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end
`endif

    assign bus.hor_addr = hor_q;
    assign bus.ver_addr = ver_q;
    assign bus.wdata    = wdata_q;
    assign bus.we       = we_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
